// File: rtl/spi_register_writer.sv
// SPI mode-0 slave that converts {16-bit register number, data bytes...} frames into register-write strobes.
// Optional `SPI_REGISTER_LOOPBACK_EN echoes each completed frame byte back on MISO, one byte late.
`timescale 1ns/1ps

module spi_register_writer (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_SPI_SCK,
  input  logic        i_SPI_CS_n,
  input  logic        i_SPI_MOSI,
  output logic        o_SPI_MISO,
  output logic        o_RegisterWriteEnable,
  output logic [15:0] o_RegisterWriteNumber,
  output logic [7:0]  o_RegisterWriteValue,
  output logic        o_FrameAbort
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  logic [1:0]  sck_sync_reg, cs_sync_reg, mosi_sync_reg;
  logic        sck_prev_reg, cs_prev_reg;
  logic        sck_s, cs_s, mosi_s;
  logic        sck_rise, cs_rise, cs_fall, sck_valid;

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [15:0] shift_reg, shift_next;
  logic [15:0] addr_reg, addr_next;
  logic        byte_done_reg, byte_done_next;
  logic        we_reg, we_next;
  logic [15:0] num_reg, num_next;
  logic [7:0]  val_reg, val_next;
  logic        abort_reg, abort_next;

  // CS synchroniser resets low so a CS already asserted at reset release never looks like a new frame.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sck_sync_reg  <= 2'b00;
      cs_sync_reg   <= 2'b00;
      mosi_sync_reg <= 2'b00;
      sck_prev_reg  <= 1'b0;
      cs_prev_reg   <= 1'b0;
    end else begin
      sck_sync_reg  <= {sck_sync_reg[0], i_SPI_SCK};
      cs_sync_reg   <= {cs_sync_reg[0], i_SPI_CS_n};
      mosi_sync_reg <= {mosi_sync_reg[0], i_SPI_MOSI};
      sck_prev_reg  <= sck_sync_reg[1];
      cs_prev_reg   <= cs_sync_reg[1];
    end
  end

  assign sck_s     = sck_sync_reg[1];
  assign cs_s      = cs_sync_reg[1];
  assign mosi_s    = mosi_sync_reg[1];
  assign sck_rise  = sck_s & ~sck_prev_reg;
  assign cs_rise   = cs_s & ~cs_prev_reg;
  assign cs_fall   = ~cs_s & cs_prev_reg;
  assign sck_valid = sck_rise & ~cs_s & ~cs_rise;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= 16'h0000;
      addr_reg      <= 16'h0000;
      byte_done_reg <= 1'b0;
      we_reg        <= 1'b0;
      num_reg       <= 16'h0000;
      val_reg       <= 8'h00;
      abort_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      addr_reg      <= addr_next;
      byte_done_reg <= byte_done_next;
      we_reg        <= we_next;
      num_reg       <= num_next;
      val_reg       <= val_next;
      abort_reg     <= abort_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    addr_next      = addr_reg;
    byte_done_next = 1'b0;
    we_next        = 1'b0;
    num_next       = num_reg;
    val_next       = val_reg;
    abort_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (cs_fall) begin
          shift_next   = 16'h0000;
          bit_cnt_next = 4'd0;
          state_next   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          abort_next = (bit_cnt_reg != 4'd0);
        end else if (sck_valid) begin
          shift_next = {shift_reg[14:0], mosi_s};
          if (bit_cnt_reg == 4'd15) begin
            addr_next    = {shift_reg[14:0], mosi_s};
            bit_cnt_next = 4'd0;
            state_next   = ST_DATA;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
          abort_next = (bit_cnt_reg != 4'd0);
        end else if (sck_valid) begin
          shift_next = {shift_reg[14:0], mosi_s};
          if (bit_cnt_reg == 4'd7) begin
            bit_cnt_next   = 4'd0;
            byte_done_next = 1'b1;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Completed byte is issued one cycle after its last bit lands; address then advances for bursts.
    if (byte_done_reg) begin
      we_next   = 1'b1;
      num_next  = addr_reg;
      val_next  = shift_reg[7:0];
      addr_next = addr_reg + 16'd1;
    end
  end

  assign o_RegisterWriteEnable = we_reg;
  assign o_RegisterWriteNumber = num_reg;
  assign o_RegisterWriteValue  = val_reg;
  assign o_FrameAbort          = abort_reg;

`ifdef SPI_REGISTER_LOOPBACK_EN
  logic       sck_fall_valid, byte_end;
  logic [7:0] echo_reg, tx_reg;
  logic       load_pending_reg, miso_reg;

  assign sck_fall_valid = ~sck_s & sck_prev_reg & ~cs_s & (state_reg != ST_IDLE);
  assign byte_end       = sck_valid & (state_reg != ST_IDLE) & (bit_cnt_reg[2:0] == 3'd7);

  // Each frame byte is captured at its last rising edge and replayed from the falling edge that follows.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      echo_reg         <= 8'h00;
      tx_reg           <= 8'h00;
      load_pending_reg <= 1'b0;
      miso_reg         <= 1'b0;
    end else if (cs_fall || cs_rise) begin
      tx_reg           <= 8'h00;
      load_pending_reg <= 1'b0;
      miso_reg         <= 1'b0;
    end else begin
      if (byte_end) begin
        echo_reg         <= {shift_reg[6:0], mosi_s};
        load_pending_reg <= 1'b1;
      end
      if (sck_fall_valid) begin
        if (load_pending_reg) begin
          miso_reg         <= echo_reg[7];
          tx_reg           <= {echo_reg[6:0], 1'b0};
          load_pending_reg <= 1'b0;
        end else begin
          miso_reg <= tx_reg[7];
          tx_reg   <= {tx_reg[6:0], 1'b0};
        end
      end
    end
  end

  assign o_SPI_MISO = miso_reg;
`else
  assign o_SPI_MISO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_register_writer.sv
// Self-checking bench for spi_register_writer: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps

module tb_spi_register_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        miso, we, abort;
  logic [15:0] num;
  logic [7:0]  val;

  spi_register_writer dut (
    .i_Clock               (clk),
    .i_Reset_n             (rst_n),
    .i_SPI_SCK             (sck),
    .i_SPI_CS_n            (cs_n),
    .i_SPI_MOSI            (mosi),
    .o_SPI_MISO            (miso),
    .o_RegisterWriteEnable (we),
    .o_RegisterWriteNumber (num),
    .o_RegisterWriteValue  (val),
    .o_FrameAbort          (abort)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] obs_q[$];
  int          obs_cyc_q[$];
  logic [23:0] exp_q[$];
  int          abort_cnt = 0;
  int          exp_abort = 0;
  int          last_rise_cyc = 0;
  logic [63:0] rx_word = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      obs_q.push_back({num, val});
      obs_cyc_q.push_back(cyc);
      $display("write: num=%h val=%h cycle=%0d", num, val, cyc);
    end
    if (abort) abort_cnt++;
  end

  task automatic clear_scoreboard();
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
    abort_cnt = 0;
    exp_abort = 0;
  endtask

  // Frame-level model: first 16 bits are the register number, each full byte after it is a write.
  task automatic model_frame(input logic [63:0] bits, input int n);
    logic [15:0] a;
    if (n >= 16) begin
      a = bits[n-1 -: 16];
      for (int i = 0; i < (n - 16) / 8; i++)
        exp_q.push_back({a + 16'(i), bits[n-17-8*i -: 8]});
    end
    if ((n > 0 && n < 16) || (n > 16 && (n - 16) % 8 != 0)) exp_abort++;
  endtask

  task automatic spi_start(input int half);
    cs_n = 1'b0;
    #(half);
  endtask

  task automatic spi_bits(input logic [63:0] bits, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      #(half);
      rx_word = {rx_word[62:0], miso};
      sck = 1'b1;
      last_rise_cyc = cyc;
      #(half);
      sck = 1'b0;
    end
  endtask

  task automatic spi_end(input int half);
    #(half);
    cs_n = 1'b1;
    #(4 * half);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n, input int half);
    spi_start(half);
    spi_bits(bits, n, half);
    spi_end(half);
    model_frame(bits, n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (we !== 1'b0)     begin n_bad++; $display("FAIL reset_we got=%b want=0", we); end
    n_cmp++; if (num !== 16'h0)   begin n_bad++; $display("FAIL reset_num got=%h want=0000", num); end
    n_cmp++; if (val !== 8'h0)    begin n_bad++; $display("FAIL reset_val got=%h want=00", val); end
    n_cmp++; if (abort !== 1'b0)  begin n_bad++; $display("FAIL reset_abort got=%b want=0", abort); end
    n_cmp++; if (miso !== 1'b0)   begin n_bad++; $display("FAIL reset_miso got=%b want=0", miso); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_single_write();
    clear_scoreboard();
    @(posedge clk);
    #2;
    send_frame({40'd0, 16'hC005, 8'h7F}, 24, 40);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL single_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_cmp++; if (obs_q[0] !== 24'hC0057F) begin n_bad++; $display("FAIL single_data got=%h want=c0057f", obs_q[0]); end
      n_cmp++; if (obs_cyc_q[0] - last_rise_cyc != 4) begin n_bad++; $display("FAIL single_latency got=%0d want=4", obs_cyc_q[0] - last_rise_cyc); end
    end
    n_cmp++; if (abort_cnt != 0) begin n_bad++; $display("FAIL single_abort got=%0d want=0", abort_cnt); end
  endtask

  task automatic test_burst();
    clear_scoreboard();
    send_frame({24'd0, 16'hC0FF, 24'h112233}, 40, 40);
    send_frame({32'd0, 16'hFFFF, 16'hAABB}, 32, 40);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL burst_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL burst_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (abort_cnt != 0) begin n_bad++; $display("FAIL burst_abort got=%0d want=0", abort_cnt); end
  endtask

  task automatic test_abort();
    clear_scoreboard();
    send_frame({43'd0, 16'hC000, 5'b10110}, 21, 40);
    n_cmp++; if (abort_cnt != 1) begin n_bad++; $display("FAIL abort_data_bits got=%0d want=1", abort_cnt); end
    send_frame({54'd0, 10'h2A5}, 10, 40);
    n_cmp++; if (abort_cnt != 2) begin n_bad++; $display("FAIL abort_addr_bits got=%0d want=2", abort_cnt); end
    send_frame(64'd0, 0, 40);
    send_frame({40'd0, 16'h1234, 8'hAB}, 24, 40);
    n_cmp++; if (abort_cnt != exp_abort) begin n_bad++; $display("FAIL abort_total got=%0d want=%0d", abort_cnt, exp_abort); end
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL abort_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_cmp++; if (obs_q[0] !== 24'h1234AB) begin n_bad++; $display("FAIL abort_recover got=%h want=1234ab", obs_q[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_scoreboard();
    spi_start(40);
    spi_bits({44'd0, 20'hC123A}, 20, 40);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({we, num, val, abort, miso} !== 27'd0) begin n_bad++; $display("FAIL midreset_outputs got=%b%h%h%b%b want=all zero", we, num, val, abort, miso); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spi_bits({56'd0, 8'hFF}, 8, 40);
    spi_end(40);
    send_frame({40'd0, 16'h8000, 8'h01}, 24, 40);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL midreset_count got=%0d want=1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      n_cmp++; if (obs_q[0] !== 24'h800001) begin n_bad++; $display("FAIL midreset_data got=%h want=800001", obs_q[0]); end
    end
    n_cmp++; if (abort_cnt != 0) begin n_bad++; $display("FAIL midreset_abort got=%0d want=0", abort_cnt); end
  endtask

  task automatic test_loopback();
    logic [31:0] want;
    clear_scoreboard();
    rx_word = 64'd0;
    send_frame({40'd0, 16'h1234, 8'h56}, 24, 80);
`ifdef SPI_REGISTER_LOOPBACK_EN
    want = 32'h00001234;
`else
    want = 32'h0;
`endif
    n_cmp++; if (rx_word[23:0] !== want[23:0]) begin n_bad++; $display("FAIL loopback_frame1 got=%h want=%h", rx_word[23:0], want[23:0]); end
    rx_word = 64'd0;
    send_frame({32'd0, 16'hA5C3, 16'h9E71}, 32, 80);
`ifdef SPI_REGISTER_LOOPBACK_EN
    want = 32'h00A5C39E;
`else
    want = 32'h0;
`endif
    n_cmp++; if (rx_word[31:0] !== want) begin n_bad++; $display("FAIL loopback_frame2 got=%h want=%h", rx_word[31:0], want); end
    n_cmp++; if (obs_q.size() != 3) begin n_bad++; $display("FAIL loopback_writes got=%0d want=3", obs_q.size()); end
  endtask

  task automatic test_random_frames();
    logic [63:0] bits;
    int          n, r;
    clear_scoreboard();
    for (int f = 0; f < 150; f++) begin
      #($urandom_range(0, 9));
      bits = {$urandom, $urandom};
      r = int'($urandom_range(0, 9));
      if (r < 7)      n = 16 + 8 * int'($urandom_range(0, 3));
      else if (r < 9) n = 16 + 8 * int'($urandom_range(0, 2)) + int'($urandom_range(1, 7));
      else            n = int'($urandom_range(0, 15));
      send_frame(bits, n, 40);
    end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_write[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (abort_cnt != exp_abort) begin n_bad++; $display("FAIL random_abort got=%0d want=%0d", abort_cnt, exp_abort); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst();
    test_abort();
    test_reset_mid_frame();
    test_loopback();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_register_writer.md
# spi_register_writer

SPI peripheral (mode 0) that turns serial frames from the host microcontroller into the synth's parallel register-write interface. It sits in front of `synth` and drives its `i_RegisterWriteEnable`, `i_RegisterWriteNumber` and `i_RegisterWriteValue` inputs. Each frame carries a 16-bit register number followed by one or more data bytes, with address auto-increment for burst loading of voice-operator tables. SPI pins are oversampled in the `i_Clock` domain; there is no second clock.

## Interface
- No parameters.
- `i_Clock` in 1: system clock. Must be at least 8× the SCK frequency.
- `i_Reset_n` in 1: asynchronous, active-low reset.
- `i_SPI_SCK` in 1: SPI clock, asynchronous to `i_Clock`.
- `i_SPI_CS_n` in 1: chip select, active-low, asynchronous.
- `i_SPI_MOSI` in 1: serial data in, MSB first.
- `o_SPI_MISO` out 1: serial data out (see Configuration).
- `o_RegisterWriteEnable` out 1: single-cycle write strobe.
- `o_RegisterWriteNumber` out 16: register number. Held until the next strobe.
- `o_RegisterWriteValue` out 8: register value. Held until the next strobe.
- `o_FrameAbort` out 1: single-cycle pulse when a frame ends on a non-byte boundary.

## Operation
- **Input synchronisation:** SCK, CS_n and MOSI each pass through a 2-FF synchroniser. A further register on SCK and CS_n provides edge detection. MOSI is sampled on the cycle a synchronised SCK rising edge is detected.
- **SCK gating:** SCK edges count only while synchronised CS_n is low. If a CS_n rising edge and an SCK rising edge are detected in the same cycle, CS_n wins and the SCK edge is ignored.
- **IDLE:** CS_n high. A CS_n falling edge clears the shift register and the bit counter, then the block enters ADDR.
- **ADDR:** shift in 16 bits. After the 16th bit, load the address register and enter DATA with the bit counter at 0.
- **DATA:** shift in 8 bits. After the 8th bit, in the next cycle:
  - `o_RegisterWriteNumber` takes the address and `o_RegisterWriteValue` takes the byte.
  - `o_RegisterWriteEnable` is 1 for exactly one cycle.
  - The address register increments by 1, wrapping 0xFFFF→0x0000.
  - The block stays in DATA for the next byte.
- **CS_n rising edge:** always returns to IDLE.
  - In ADDR with any number of bits received, or in DATA with 1–7 bits: no write, `o_FrameAbort` pulses for 1 cycle.
  - In DATA with 0 bits (clean byte boundary): normal end, no pulse.
  - CS_n rising in ADDR with 0 bits (CS toggled with no clocks): no pulse.
- **Reset mid-frame:** all state clears asynchronously. The partial frame is discarded with no write and no abort pulse. After release, the block waits for a fresh CS_n falling edge; a CS_n that is already low is ignored until it goes high and then low again.
- **Reset values:**
  - `o_RegisterWriteEnable`=0, `o_RegisterWriteNumber`=0x0000, `o_RegisterWriteValue`=0x00.
  - `o_FrameAbort`=0, `o_SPI_MISO`=0.
  - State = IDLE.

## Timing
- **Edge detect delay:** an SCK rising edge at the pin is detected 3 `i_Clock` edges later (2 synchroniser stages plus 1 edge stage).
- **Write latency:** the write strobe asserts 1 cycle after detection of the 8th data-bit edge, i.e. 4 cycles after that SCK edge at the pin.
- **Back-to-back strobes** are separated by at least 8 SCK periods. No backpressure: `synth` accepts a write every cycle.
- **Hold:** number and value stay stable from the strobe cycle until the next strobe.
- **MISO:** updates in the cycle a synchronised SCK falling edge is detected, so it is valid well before the next rising edge when the 8× ratio holds. The first bit of each byte is driven on the detected CS_n falling edge or on the falling edge that ends the previous byte.

## Configuration
- **`SPI_REGISTER_LOOPBACK_EN` defined:** `o_SPI_MISO` shifts out, MSB first, the most recently completed byte of the current frame, delayed by one byte.
  - During the first byte of a frame it shifts out 0x00.
  - Lets the host verify every byte it sent.
- **Not defined:** `o_SPI_MISO` is constant 0 and the echo register is removed.

## Test plan
- **Single write:** CS low, send 0xC005 then 0x7F, CS high → one strobe with Number=0xC005 and Value=0x7F, strobe latency 4 cycles after the last SCK rise, `o_FrameAbort`=0.
- **Burst:** send 0xC0FF, then 0x11, 0x22, 0x33 → three strobes with Number=0xC0FF, 0xC100, 0xC101 and Values 0x11, 0x22, 0x33. Separately, start at 0xFFFF with two bytes → Numbers 0xFFFF then 0x0000.
- **Abort:**
  - 0xC000 then 5 bits, CS high → no strobe, one-cycle `o_FrameAbort`.
  - 10 address bits, CS high → `o_FrameAbort`, no strobe.
  - The next full frame still writes correctly.
- **Reset mid-frame:** assert `i_Reset_n`=0 after 20 bits, release, send 0x8000 and 0x01 → exactly one strobe with Number=0x8000, Value=0x01; all outputs are 0 during reset.
- **Loopback (macro defined):** send 0x12, 0x34, 0x56 → MISO carries 0x00, 0x12, 0x34. Macro undefined → MISO stays 0 throughout.
- **Clock ratio:** SCK at exactly `i_Clock`/8 with random CS/SCK phase relative to `i_Clock`, 1000 random frames → every strobe matches the reference model with no drops or duplicates.
